// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Imported by the register file top and its pending-bit scoreboard.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int XLEN_DEF   = 32;
   localparam int NREGS_DEF  = 32;
   localparam int NRP_DEF    = 2;
   localparam int BYPASS_DEF = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on allocation,
// cleared on writeback, flushed on a clear sweep; entry 0 never pends.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = $clog2(NREGS_DEF),
   parameter int NRP   = NRP_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              set_en,
   input  logic [AW-1:0]     set_idx,
   input  logic              clr_en,
   input  logic [AW-1:0]     clr_idx,
   input  logic [NRP*AW-1:0] q_idx,
   output logic [NRP-1:0]    q_busy
);

   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_nxt;

   // next pending vector: flush beats set, set beats clear
   always_comb begin
      pending_nxt = pending;
      if (flush) begin
         pending_nxt = '0;
      end else begin
         if (clr_en) pending_nxt[clr_idx] = 1'b0;
         if (set_en) pending_nxt[set_idx] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   // pending bits register, cleared asynchronously on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= pending_nxt;
   end

   // raw pending lookup for every read port
   always_comb begin
      q_busy = '0;
      for (int i = 0; i < NRP; i++)
         q_busy[i] = pending[q_idx[i*AW +: AW]];
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with zero-sweep clear, optional write
// forwarding and a pending-result scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int  XLEN   = XLEN_DEF,
   parameter int  NREGS  = NREGS_DEF,
   parameter int  NRP    = NRP_DEF,
   parameter int  BYPASS = BYPASS_DEF,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                clear_req,
   output logic                ready,
   input  logic                write_en,
   input  logic [AW-1:0]       rd,
   input  logic [XLEN-1:0]     rd_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_rd,
   input  logic [NRP*AW-1:0]   rs,
   output logic [NRP*XLEN-1:0] rs_data,
   output logic [NRP-1:0]      rs_busy
);

   localparam logic [AW-1:0] ONE  = AW'(1);
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   state_t          state;
   logic [AW-1:0]   cnt;
   logic            wr_ok;
   logic            al_ok;
   logic            we;
   logic [AW-1:0]   wa;
   logic [XLEN-1:0] wd;
   logic [NRP-1:0]  busy_raw;
   logic [XLEN-1:0] mem [NREGS];

   assign ready = (state == IDLE);
   assign wr_ok = write_en && ready && (rd != '0);
   assign al_ok = alloc_en && ready && (alloc_rd != '0);

   // sweep sequencer: clear_req (re)starts the sweep at entry 1
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= CLEAR;
         cnt   <= ONE;
      end else if (clear_req) begin
         state <= CLEAR;
         cnt   <= ONE;
      end else if (state == CLEAR) begin
         if (cnt == LAST) state <= IDLE;
         cnt <= cnt + ONE;
      end
   end

   // single write port shared by the sweep and normal writes
   always_comb begin
      we = 1'b0;
      wa = rd;
      wd = rd_data;
      if (state == CLEAR) begin
         we = 1'b1;
         wa = cnt;
         wd = '0;
      end else if (wr_ok) begin
         we = 1'b1;
      end
   end

   // storage array; contents only defined through the sweep
   always_ff @(posedge aclk) begin
      if (we) mem[wa] <= wd;
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW),
      .NRP   (NRP)
   ) u_sb (
      .clk     (aclk),
      .rst     (areset),
      .flush   (clear_req),
      .set_en  (al_ok),
      .set_idx (alloc_rd),
      .clr_en  (wr_ok),
      .clr_idx (rd),
      .q_idx   (rs),
      .q_busy  (busy_raw)
   );

   for (genvar g = 0; g < NRP; g++) begin : g_rp
      logic [AW-1:0] idx;
      logic          hit;
      logic          keep;

      assign idx  = rs[g*AW +: AW];
      assign hit  = (BYPASS != 0) && wr_ok && (rd == idx);
      assign keep = al_ok && (alloc_rd == idx);

      assign rs_data[g*XLEN +: XLEN] =
         (!ready || idx == '0) ? '0 :
         hit                   ? rd_data :
                                 mem[idx];

      assign rs_busy[g] = busy_raw[g] && (!hit || keep);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vectors, sweep timing
// sequences and random traffic against a behavioural model.
module tb_regfile_mp;

   logic        aclk;
   logic        areset;
   logic        clear_req;
   logic        write_en;
   logic [4:0]  rd;
   logic [31:0] rd_data;
   logic        alloc_en;
   logic [4:0]  alloc_rd;
   logic [9:0]  rs;
   logic        ready1;
   logic [63:0] rs_data1;
   logic [1:0]  rs_busy1;
   logic        ready0;
   logic [63:0] rs_data0;
   logic [1:0]  rs_busy0;

   int total;
   int bad;

   int unsigned left;
   logic [31:0] regs [32];
   logic [31:0] pend;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        ae;
      logic [4:0]  ard;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        b0;
      logic        b1;
      logic [31:0] n0;
   } vec_t;

   vec_t tbl [12];

   regfile_mp #(.BYPASS(1)) dut1 (
      .aclk      (aclk),
      .areset    (areset),
      .clear_req (clear_req),
      .ready     (ready1),
      .write_en  (write_en),
      .rd        (rd),
      .rd_data   (rd_data),
      .alloc_en  (alloc_en),
      .alloc_rd  (alloc_rd),
      .rs        (rs),
      .rs_data   (rs_data1),
      .rs_busy   (rs_busy1)
   );

   regfile_mp #(.BYPASS(0)) dut0 (
      .aclk      (aclk),
      .areset    (areset),
      .clear_req (clear_req),
      .ready     (ready0),
      .write_en  (write_en),
      .rd        (rd),
      .rd_data   (rd_data),
      .alloc_en  (alloc_en),
      .alloc_rd  (alloc_rd),
      .rs        (rs),
      .rs_data   (rs_data0),
      .rs_busy   (rs_busy0)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   function automatic logic m_ready();
      return !areset && (left == 0);
   endfunction

   function automatic logic [31:0] exp_data(input logic [4:0] idx,
                                            input logic byp);
      logic hit;
      if (!m_ready() || idx == 5'd0) return 32'd0;
      hit = write_en && rd == idx;
      if (byp && hit) return rd_data;
      return regs[idx];
   endfunction

   function automatic logic exp_busy(input logic [4:0] idx,
                                     input logic byp);
      logic hit;
      logic keep;
      if (!m_ready() || idx == 5'd0) return 1'b0;
      hit  = write_en && rd == idx;
      keep = alloc_en && alloc_rd == idx;
      if (byp && hit && !keep) return 1'b0;
      return pend[idx];
   endfunction

   task automatic cmp_model();
      logic [4:0] idx;
      chk("ready_byp", {63'd0, ready1}, {63'd0, m_ready()});
      chk("ready_nobyp", {63'd0, ready0}, {63'd0, m_ready()});
      for (int p = 0; p < 2; p++) begin
         idx = rs[p*5 +: 5];
         chk($sformatf("data_byp%0d", p),
             {32'd0, rs_data1[p*32 +: 32]}, {32'd0, exp_data(idx, 1'b1)});
         chk($sformatf("busy_byp%0d", p),
             {63'd0, rs_busy1[p]}, {63'd0, exp_busy(idx, 1'b1)});
         chk($sformatf("data_nobyp%0d", p),
             {32'd0, rs_data0[p*32 +: 32]}, {32'd0, exp_data(idx, 1'b0)});
         chk($sformatf("busy_nobyp%0d", p),
             {63'd0, rs_busy0[p]}, {63'd0, exp_busy(idx, 1'b0)});
      end
   endtask

   task automatic model_update();
      if (areset || clear_req) begin
         left = 31;
         pend = '0;
         for (int i = 0; i < 32; i++) regs[i] = '0;
      end else if (left > 0) begin
         left--;
      end else begin
         if (write_en && rd != 5'd0) begin
            regs[rd] = rd_data;
            pend[rd] = 1'b0;
         end
         if (alloc_en && alloc_rd != 5'd0) pend[alloc_rd] = 1'b1;
      end
   endtask

   task automatic sample();
      @(negedge aclk);
      cmp_model();
   endtask

   task automatic adv();
      @(posedge aclk);
      model_update();
      #1;
   endtask

   task automatic idle_in();
      clear_req = 1'b0;
      write_en  = 1'b0;
      alloc_en  = 1'b0;
      rd        = '0;
      rd_data   = '0;
      alloc_rd  = '0;
   endtask

   task automatic wait_ready(input string nm, input int exp);
      int n;
      n = 0;
      for (int c = 0; c < 100; c++) begin
         sample();
         if (ready1) break;
         n++;
         adv();
      end
      chk(nm, 64'(n), 64'(exp));
      adv();
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ready"}, {62'd0, ready1, ready0}, 64'd0);
      chk({nm, "_data1"}, rs_data1, 64'd0);
      chk({nm, "_data0"}, rs_data0, 64'd0);
      chk({nm, "_busy"}, {60'd0, rs_busy1, rs_busy0}, 64'd0);
   endtask

   initial begin
      int n;
      total = 0;
      bad   = 0;
      idle_in();
      rs     = '0;
      areset = 1'b1;
      left   = 31;
      pend   = '0;
      for (int i = 0; i < 32; i++) regs[i] = '0;

      tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5,
                  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5,
                  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0,
                  32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
                  32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
      tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7,
                  32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                  32'h0, 32'h0, 1'b1, 1'b1, 32'h0};
      tbl[6]  = '{1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd3,
                  32'h77, 32'h0, 1'b0, 1'b0, 32'h0};
      tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                  32'h77, 32'h77, 1'b0, 1'b0, 32'h77};
      tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7,
                  32'h77, 32'h77, 1'b0, 1'b0, 32'h77};
      tbl[9]  = '{1'b1, 5'd7, 32'h99, 1'b1, 5'd7, 5'd7, 5'd7,
                  32'h99, 32'h99, 1'b1, 1'b1, 32'h77};
      tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                  32'h99, 32'h99, 1'b1, 1'b1, 32'h99};
      tbl[11] = '{1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd7,
                  32'h0, 32'h99, 1'b0, 1'b1, 32'h0};

      // power-on reset and first sweep
      repeat (2) @(posedge aclk);
      #1;
      chk_zero("reset");
      areset = 1'b0;
      wait_ready("por_sweep_len", 31);

      // directed vectors
      foreach (tbl[k]) begin
         write_en = tbl[k].we;
         rd       = tbl[k].rd;
         rd_data  = tbl[k].wd;
         alloc_en = tbl[k].ae;
         alloc_rd = tbl[k].ard;
         rs       = {tbl[k].r1, tbl[k].r0};
         @(negedge aclk);
         chk($sformatf("vec%0d_d0", k), {32'd0, rs_data1[31:0]},
             {32'd0, tbl[k].d0});
         chk($sformatf("vec%0d_d1", k), {32'd0, rs_data1[63:32]},
             {32'd0, tbl[k].d1});
         chk($sformatf("vec%0d_busy", k), {62'd0, rs_busy1},
             {62'd0, tbl[k].b1, tbl[k].b0});
         chk($sformatf("vec%0d_n0", k), {32'd0, rs_data0[31:0]},
             {32'd0, tbl[k].n0});
         cmp_model();
         adv();
      end
      idle_in();

      // clear with a restart at sweep cycle 10
      write_en = 1'b1;
      rd       = 5'd3;
      rd_data  = 32'h55;
      rs       = {5'd3, 5'd3};
      sample();
      adv();
      idle_in();
      clear_req = 1'b1;
      sample();
      adv();
      n = 0;
      for (int c = 0; c < 100; c++) begin
         clear_req = (n == 9);
         write_en  = (n == 4);
         rd        = 5'd4;
         rd_data   = 32'hAAAA5555;
         sample();
         if (ready1) break;
         n++;
         adv();
      end
      chk("clr_restart_len", 64'(n), 64'd41);
      idle_in();
      rs = {5'd4, 5'd3};
      @(negedge aclk);
      chk("clr_x3_x4", rs_data1, 64'd0);
      cmp_model();
      adv();

      // random traffic
      for (int c = 0; c < 600; c++) begin
         clear_req = ($urandom_range(0, 79) == 0);
         write_en  = $urandom_range(0, 1) == 1;
         rd        = 5'($urandom_range(0, 9));
         rd_data   = $urandom;
         alloc_en  = $urandom_range(0, 2) == 0;
         alloc_rd  = 5'($urandom_range(0, 9));
         rs        = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
         if ($urandom_range(0, 7) == 0) rs[9:5] = rs[4:0];
         if ($urandom_range(0, 15) == 0) rd = 5'($urandom_range(10, 31));
         sample();
         if (rs[9:5] == rs[4:0])
            chk("same_idx", {rs_busy1[1], rs_data1[63:32]},
                {rs_busy1[0], rs_data1[31:0]});
         adv();
      end
      idle_in();
      wait_ready("rand_settle", left);

      // reset in mid-operation with a pending entry
      write_en = 1'b1;
      rd       = 5'd9;
      rd_data  = 32'h1111;
      sample();
      adv();
      idle_in();
      alloc_en = 1'b1;
      alloc_rd = 5'd10;
      sample();
      adv();
      idle_in();
      rs = {5'd10, 5'd9};
      @(negedge aclk);
      chk("preop_data", {32'd0, rs_data1[31:0]}, 64'h1111);
      chk("preop_busy", {62'd0, rs_busy1}, 64'd2);
      cmp_model();
      #2;
      areset = 1'b1;
      #1;
      chk_zero("midop_rst");
      left = 31;
      pend = '0;
      adv();
      areset = 1'b0;
      wait_ready("midop_sweep_len", 31);

      // reset in mid-sweep at sweep cycle 5
      clear_req = 1'b1;
      sample();
      adv();
      clear_req = 1'b0;
      repeat (4) begin
         sample();
         adv();
      end
      #2;
      areset = 1'b1;
      #1;
      chk_zero("midsweep_rst");
      left = 31;
      pend = '0;
      adv();
      adv();
      areset = 1'b0;
      wait_ready("midsweep_len", 31);
      sample();
      adv();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, at least 4; entry 0 hardwired to zero.
REQ-003 SHALL have parameter NRP, default 2, number of combinational read ports.
REQ-004 SHALL have parameter BYPASS, default 1, enables write-to-read forwarding when 1.
REQ-005 SHALL derive AW = log2(NREGS) as a localparam.
REQ-006 SHALL have port: aclk  in  1  single clock; all state on rising edge.
REQ-007 SHALL have port: areset  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port: clear_req  in  1  one-cycle request to zero all registers.
REQ-009 SHALL have port: ready  out  1  high when idle and accepting writes and allocations.
REQ-010 SHALL have port: write_en  in  1  write strobe.
REQ-011 SHALL have port: rd  in  AW  write destination index.
REQ-012 SHALL have port: rd_data  in  XLEN  write data.
REQ-013 SHALL have port: alloc_en  in  1  mark a register pending (result in flight).
REQ-014 SHALL have port: alloc_rd  in  AW  index to mark pending.
REQ-015 SHALL have port: rs  in  NRP*AW  packed read indices; port i occupies bits [i*AW +: AW].
REQ-016 SHALL have port: rs_data  out  NRP*XLEN  packed read data, same packing.
REQ-017 SHALL have port: rs_busy  out  NRP  pending flag of each read index.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and CLEAR; ready = (state == IDLE).
REQ-019 In IDLE, SHALL move to CLEAR on clear_req, with clear counter loaded to 1 and all pending bits cleared at that edge.
REQ-020 In CLEAR, SHALL zero entry[counter] each cycle and increment the counter; after zeroing entry NREGS-1, SHALL return to IDLE, so ready rises exactly NREGS-1 cycles after entering CLEAR.
REQ-021 SHALL restart the sweep when clear_req arrives during CLEAR: counter reloads to 1 and the state stays CLEAR.
REQ-022 SHALL perform a write only when write_en && ready && rd != 0; the new value becomes visible in storage after the rising edge.
REQ-023 SHALL ignore write_en and alloc_en while ready is low; no error is flagged.
REQ-024 Read port i SHALL output 0 when rs_i == 0 or ready is low; otherwise it SHALL output entry[rs_i], combinationally.
REQ-025 With BYPASS=1, read port i SHALL output rd_data when a qualifying write (REQ-022) targets rs_i in the same cycle; with BYPASS=0, it SHALL output the old value.
REQ-026 SHALL set pending[alloc_rd] on alloc_en && ready && alloc_rd != 0; pending[0] is constant 0.
REQ-027 SHALL clear pending[rd] on a qualifying write.
REQ-028 When a write and an allocation target the same index in the same cycle, the set SHALL win.
REQ-029 rs_busy[i] SHALL equal pending[rs_i]; with BYPASS=1 it SHALL read 0 during a same-cycle qualifying write to rs_i (REQ-028 exception: remains 1 when alloc also targets it).
REQ-030 Multiple read ports addressing the same index SHALL all return identical data and busy.

Reset
REQ-031 Asserting areset SHALL immediately force state=CLEAR, counter=1, all pending=0, ready=0, rs_data=0, rs_busy=0.
REQ-032 After areset deasserts, SHALL perform the full sweep (REQ-020); storage is not async-reset, so power-on contents are defined only via the sweep.
REQ-033 Reset asserted mid-sweep or mid-operation SHALL abandon the sweep and restart per REQ-031.

Structure
REQ-034 Package regfile_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and default parameter constants.
REQ-035 The pending-bit scoreboard SHALL be a sub-module regfile_scoreboard (NREGS, AW, NRP parameters; set/clear/query ports).
REQ-036 Storage SHALL be a plain array written by a single always_ff; a single synchronous write port.

Verification
REQ-037 Release areset -> ready low for exactly 31 cycles (NREGS=32), then high; all reads return 0.
REQ-038 Write x5=0xDEADBEEF with rs0=5 in the same cycle -> rs_data[0]=0xDEADBEEF same cycle (BYPASS=1), old value with BYPASS=0; next cycle both builds read 0xDEADBEEF.
REQ-039 Write rd=0, data 0x1234 -> read x0 returns 0; rs_busy for x0 stays 0.
REQ-040 alloc x7 -> rs_busy=1 on a port reading x7; write x7 -> busy 0 on that cycle (BYPASS=1); simultaneous alloc+write x7 -> busy stays 1.
REQ-041 Write x3=0x55, clear_req, second clear_req at sweep cycle 10 -> ready low 10+31 cycles total; x3 reads 0; writes during sweep are dropped.
REQ-042 Assert areset mid-sweep at cycle 5 -> outputs immediately zero; full 31-cycle sweep after release.
